// File: rtl/lpc_host_io_master.sv
// LPC host-side I/O read/write initiator (START..SYNC..TAR framing).
// Define LPC_HOST_ABORT_EN to add an LFRAME# abort sequence after a timeout.
module lpc_host_io_master #(
  parameter int SYNC_TIMEOUT  = 8,
  parameter int LONG_WAIT_MAX = 1023,
  parameter int TMR_W         = 10
) (
  input  logic        LpcClock,
  input  logic        PciReset,
  input  logic        Req,
  input  logic        ReqWr,
  input  logic [15:0] ReqAddr,
  input  logic [7:0]  ReqData,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  RdData,
  output logic [1:0]  Status,
  output logic        LpcFrame,
  inout  wire  [3:0]  LpcBus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_CYC   = 4'd2;
  localparam logic [3:0] S_ADDR  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_HTAR  = 4'd5;
  localparam logic [3:0] S_SYNC  = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_PTAR  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;
  localparam logic [3:0] S_ABORT = 4'd10;
  localparam logic [3:0] S_AIDLE = 4'd11;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  logic [3:0]       state;
  logic [1:0]       cnt;
  logic             wr;
  logic [15:0]      addr;
  logic [7:0]       wdata;
  logic [7:0]       rd_buf;
  logic [TMR_W-1:0] tmr;
  logic             long_wait;
  logic             err;

  logic             bus_oe;
  logic [3:0]       bus_do;
  logic [3:0]       addr_nib;
  logic             sync_ok;
  logic             sync_err;
  logic             sync_lw;
  logic             sync_to;
  logic [TMR_W-1:0] tmr_inc;
  logic [TMR_W-1:0] tmr_lim;

  assign LpcBus   = bus_oe ? bus_do : 4'bzzzz;
  assign Done     = (state == S_DONE);
  assign Busy     = !(state == S_IDLE || state == S_DONE);
  assign LpcFrame = !(state == S_START || state == S_ABORT);

  always_comb begin
    addr_nib = addr[3:0];
    unique case (cnt)
      2'd0: addr_nib = addr[15:12];
      2'd1: addr_nib = addr[11:8];
      2'd2: addr_nib = addr[7:4];
      2'd3: addr_nib = addr[3:0];
      default: addr_nib = addr[3:0];
    endcase
  end

  always_comb begin
    bus_oe = 1'b1;
    bus_do = 4'b0000;
    unique case (1'b1)
      state == S_START: bus_do = 4'b0000;
      state == S_CYC:   bus_do = wr ? 4'b0010 : 4'b0000;
      state == S_ADDR:  bus_do = addr_nib;
      state == S_WDATA: bus_do = cnt[0] ? wdata[7:4] : wdata[3:0];
      state == S_HTAR && cnt == 2'd0: bus_do = 4'b1111;
      state == S_ABORT: bus_do = 4'b1111;
      default: bus_oe = 1'b0;
    endcase
  end

  // Once long wait is seen the wider limit sticks for the rest of SYNC
  always_comb begin
    sync_ok  = (LpcBus == 4'b0000);
    sync_err = (LpcBus == 4'b1010);
    sync_lw  = (LpcBus == 4'b0110);
    tmr_inc  = tmr + TMR_W'(1);
    tmr_lim  = (long_wait || sync_lw) ? TMR_W'(LONG_WAIT_MAX)
                                      : TMR_W'(SYNC_TIMEOUT);
    sync_to  = !sync_ok && !sync_err && (tmr_inc >= tmr_lim);
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      wr        <= 1'b0;
      addr      <= 16'h0000;
      wdata     <= 8'h00;
      rd_buf    <= 8'h00;
      tmr       <= '0;
      long_wait <= 1'b0;
      err       <= 1'b0;
      RdData    <= 8'h00;
      Status    <= ST_OK;
    end else begin
      cnt <= cnt + 2'd1;
      unique case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (Req) begin
            state <= S_START;
            wr    <= ReqWr;
            addr  <= ReqAddr;
            wdata <= ReqData;
          end
        end
        S_START: state <= S_CYC;
        S_CYC: begin
          state <= S_ADDR;
          cnt   <= 2'd0;
        end
        S_ADDR: begin
          if (cnt == 2'd3) begin
            state <= wr ? S_WDATA : S_HTAR;
            cnt   <= 2'd0;
          end
        end
        S_WDATA: begin
          if (cnt == 2'd1) begin
            state <= S_HTAR;
            cnt   <= 2'd0;
          end
        end
        S_HTAR: begin
          if (cnt == 2'd1) begin
            state     <= S_SYNC;
            tmr       <= '0;
            long_wait <= 1'b0;
          end
        end
        S_SYNC: begin
          unique case (1'b1)
            sync_ok, sync_err: begin
              err   <= sync_err;
              state <= wr ? S_PTAR : S_RDATA;
              cnt   <= 2'd0;
            end
            sync_to: begin
`ifdef LPC_HOST_ABORT_EN
              state <= S_ABORT;
              cnt   <= 2'd0;
`else
              state  <= S_DONE;
              Status <= ST_TMO;
`endif
            end
            default: begin
              tmr       <= tmr_inc;
              long_wait <= long_wait | sync_lw;
            end
          endcase
        end
        S_RDATA: begin
          if (cnt == 2'd0) begin
            rd_buf[3:0] <= LpcBus;
          end else begin
            rd_buf[7:4] <= LpcBus;
            state       <= S_PTAR;
            cnt         <= 2'd0;
          end
        end
        S_PTAR: begin
          if (cnt == 2'd1) begin
            state  <= S_DONE;
            Status <= err ? ST_ERR : ST_OK;
            if (!wr) RdData <= rd_buf;
          end
        end
        S_ABORT: begin
          if (cnt == 2'd3) begin
            state <= S_AIDLE;
            cnt   <= 2'd0;
          end
        end
        S_AIDLE: begin
          state  <= S_DONE;
          Status <= ST_TMO;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host_io_master.sv
// Directed bench for lpc_host_io_master: reads, writes, waits, timeout,
// back-to-back requests and reset in mid-frame.
module tb_lpc_host_io_master;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        busy;
  logic        done;
  logic [7:0]  rd_data;
  logic [1:0]  status;
  logic        frame;
  wire  [3:0]  lad;
  logic        t_en;
  logic [3:0]  t_val;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef LPC_HOST_ABORT_EN
  localparam int TMO_DONE = 21;
`else
  localparam int TMO_DONE = 16;
`endif

  assign lad = t_en ? t_val : 4'bzzzz;

  lpc_host_io_master dut (
    .LpcClock (clk),
    .PciReset (rst_n),
    .Req      (req),
    .ReqWr    (req_wr),
    .ReqAddr  (req_addr),
    .ReqData  (req_data),
    .Busy     (busy),
    .Done     (done),
    .RdData   (rd_data),
    .Status   (status),
    .LpcFrame (frame),
    .LpcBus   (lad)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_done_low"}, 16'(done), 16'h0);
    chk({tag, "_busy_low"}, 16'(busy), 16'h0);
  endtask

  // Called just after a negedge; edge E is the next posedge.
  task automatic txn(input bit wr, input logic [15:0] a,
                     input logic [7:0] d, input int nwait,
                     input logic [3:0] wcode, input logic [3:0] scode,
                     input logic [7:0] rdv, input bit no_tgt,
                     input int exp_done, input logic [1:0] exp_st,
                     input logic [7:0] exp_rd, input bit junk,
                     input string tag);
    logic [3:0] seq [0:9];
    int s;
    int found;
    s = wr ? 10 : 8;
    found = -1;
    seq[0] = 4'h0;
    seq[1] = wr ? 4'h2 : 4'h0;
    seq[2] = a[15:12];
    seq[3] = a[11:8];
    seq[4] = a[7:4];
    seq[5] = a[3:0];
    seq[6] = d[3:0];
    seq[7] = d[7:4];
    seq[8] = 4'hF;
    seq[9] = 4'hF;
    seq[s-2] = 4'hF;
    req      = 1'b1;
    req_wr   = wr;
    req_addr = a;
    req_data = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      t_en = 1'b0;
      t_val = 4'hF;
      if (no_tgt) begin
        if (k >= s && k < s + 8) t_en = 1'b1;
      end else begin
        if (k >= s && k < s + nwait) begin
          t_en = 1'b1;
          t_val = wcode;
        end
        if (k == s + nwait) begin
          t_en = 1'b1;
          t_val = scode;
        end
        if (!wr && k == s + nwait + 1) begin
          t_en = 1'b1;
          t_val = rdv[3:0];
        end
        if (!wr && k == s + nwait + 2) begin
          t_en = 1'b1;
          t_val = rdv[7:4];
        end
        if (k == s + nwait + (wr ? 1 : 3)) begin
          t_en = 1'b1;
          t_val = 4'hF;
        end
      end
      if (k == 0) begin
        chk({tag, "_busy_start"}, 16'(busy), 16'h1);
        chk({tag, "_done_start"}, 16'(done), 16'h0);
      end
      if (k < s - 1) begin
        chk($sformatf("%s_lad%0d", tag, k), 16'(lad), 16'(seq[k]));
        chk($sformatf("%s_frame%0d", tag, k), 16'(frame),
            16'(k != 0));
      end
      if (k == s - 1)
        chk({tag, "_htar_release"}, 16'(dut.bus_oe), 16'h0);
      if (junk && k == 4) begin
        req = 1'b1;
        req_wr = 1'b1;
        req_addr = 16'hFFFF;
      end
      if (junk && k == 5) req = 1'b0;
`ifdef LPC_HOST_ABORT_EN
      if (no_tgt && k >= s + 8 && k < s + 12) begin
        chk($sformatf("%s_abt_frame%0d", tag, k), 16'(frame), 16'h0);
        chk($sformatf("%s_abt_lad%0d", tag, k), 16'(lad), 16'hF);
      end
      if (no_tgt && k == s + 12) begin
        chk({tag, "_abt_idle_frame"}, 16'(frame), 16'h1);
        chk({tag, "_abt_idle_bus"}, 16'(dut.bus_oe), 16'h0);
      end
`else
      if (no_tgt && k == s + 8)
        chk({tag, "_tmo_frame"}, 16'(frame), 16'h1);
`endif
      if (done === 1'b1) begin
        found = k;
        break;
      end
    end
    t_en = 1'b0;
    chk({tag, "_done_cycle"}, 16'(found), 16'(exp_done));
    chk({tag, "_busy_at_done"}, 16'(busy), 16'h0);
    chk({tag, "_status"}, 16'(status), 16'(exp_st));
    chk({tag, "_rd_data"}, 16'(rd_data), 16'(exp_rd));
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    req_wr   = 1'b0;
    req_addr = 16'h0000;
    req_data = 8'h00;
    t_en     = 1'b0;
    t_val    = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_frame", 16'(frame), 16'h1);
    chk("rst_bus", 16'(dut.bus_oe), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_rd_data", 16'(rd_data), 16'h00);
    chk("rst_status", 16'(status), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b1, 16'h0C81, 8'h55, 0, 4'h5, 4'h0, 8'h00, 1'b0,
        13, 2'b00, 8'h00, 1'b0, "wr_0c81");
    txn(1'b0, 16'h0C80, 8'h00, 0, 4'h5, 4'h0, 8'hA3, 1'b0,
        13, 2'b00, 8'hA3, 1'b0, "rd_0c80_b2b");
    idle_check("after_rd");
    txn(1'b0, 16'h0C82, 8'h00, 3, 4'h5, 4'h0, 8'hB4, 1'b0,
        16, 2'b00, 8'hB4, 1'b1, "rd_short_wait");
    idle_check("after_junk");
    txn(1'b0, 16'h0C83, 8'h00, 0, 4'h5, 4'h0, 8'h00, 1'b1,
        TMO_DONE, 2'b10, 8'hB4, 1'b0, "rd_no_target");
    idle_check("after_tmo");
    txn(1'b0, 16'h0C84, 8'h00, 20, 4'h6, 4'hA, 8'h7E, 1'b0,
        33, 2'b01, 8'h7E, 1'b0, "rd_long_wait");
    idle_check("after_long");

    req      = 1'b1;
    req_wr   = 1'b1;
    req_addr = 16'hBEEF;
    req_data = 8'h99;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_addr_lad", 16'(lad), 16'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_frame", 16'(frame), 16'h1);
    chk("mid_rst_bus", 16'(dut.bus_oe), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_done", 16'(done), 16'h0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_done", 16'(done), 16'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 16'(busy), 16'h0);
    chk("post_rst_done", 16'(done), 16'h0);
    txn(1'b1, 16'h0060, 8'h3C, 0, 4'h5, 4'h0, 8'h00, 1'b0,
        13, 2'b00, 8'h00, 1'b0, "wr_after_rst");
    idle_check("end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
